// File: rtl/fetch_unit_pkg.sv
// Shared widths, FSM encodings and instruction payload for the fetch stage.
package fetch_unit_pkg;

  localparam int unsigned ADDR_SIZE   = 8;
  localparam int unsigned WORD_SIZE   = 16;
  localparam int unsigned PC_STEP_DEF = 2;

  localparam logic [1:0] FETCH_IDLE  = 2'd0;
  localparam logic [1:0] FETCH_FETCH = 2'd1;
  localparam logic [1:0] FETCH_VALID = 2'd2;
  localparam logic [1:0] FETCH_HALT  = 2'd3;

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [WORD_SIZE-1:0] word_t;

  typedef struct packed {
    word_t word;
    addr_t pc;
  } instr_t;

  // Instructions live at even addresses; redirect targets drop bit 0.
  function automatic addr_t align_even(input addr_t a);
    return {a[ADDR_SIZE-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: async-reset register with load (priority), step and hold.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int unsigned STEP      = PC_STEP_DEF,
  parameter addr_t       RESET_VAL = '0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  addr_t load_addr_i,
  input  logic  inc_i,
  output addr_t pc_o,
  output addr_t pc_next_o
);

  addr_t pc_q;
  addr_t pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_SIZE'(STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the program ROM and hands words to decode.
// Build option FETCH_HALT_EN: a zero ROM word halts fetch instead of issuing.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_STEP      = PC_STEP_DEF,
  parameter addr_t       RESET_VECTOR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 rom_boot,
  output logic [ADDR_SIZE-1:0] rom_addr,
  input  logic [WORD_SIZE-1:0] rom_data,
  output logic [WORD_SIZE-1:0] instr,
  output logic [ADDR_SIZE-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 jump_en,
  input  logic [ADDR_SIZE-1:0] jump_addr,
  output logic                 halted
);

  logic [1:0] state_q, state_d;
  instr_t     instr_q, instr_d;
  logic       valid_q, valid_d;
  logic       boot_q,  boot_d;
  addr_t      addr_q,  addr_d;
  logic       pc_load, pc_inc;
  addr_t      pc, pc_next;

  fetch_unit_pc_reg #(
    .STEP      (PC_STEP),
    .RESET_VAL (RESET_VECTOR)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (pc_load),
    .load_addr_i (align_even(jump_addr)),
    .inc_i       (pc_inc),
    .pc_o        (pc),
    .pc_next_o   (pc_next)
  );

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;
`endif

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
`ifdef FETCH_HALT_EN
    halted_d = halted_q;
`endif
    case (state_q)
      FETCH_IDLE: begin
        if (start) begin
          state_d = FETCH_FETCH;
        end
      end
      FETCH_FETCH: begin
        // A redirect drops the word on the bus this cycle.
        if (jump_en) begin
          pc_load = 1'b1;
        end
`ifdef FETCH_HALT_EN
        else if (rom_data == '0) begin
          halted_d = 1'b1;
          state_d  = FETCH_HALT;
        end
`endif
        else begin
          instr_d = '{word: rom_data, pc: pc};
          pc_inc  = 1'b1;
          valid_d = 1'b1;
          state_d = FETCH_VALID;
        end
      end
      FETCH_VALID: begin
        if (jump_en) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          state_d = FETCH_FETCH;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          state_d = FETCH_FETCH;
        end
      end
`ifdef FETCH_HALT_EN
      FETCH_HALT: begin
        if (jump_en) begin
          pc_load  = 1'b1;
          halted_d = 1'b0;
          state_d  = FETCH_FETCH;
        end
      end
`endif
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
    // ROM strobe and address are registered from the upcoming state.
    boot_d = (state_d == FETCH_FETCH);
    addr_d = boot_d ? pc_next : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      boot_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      boot_q  <= boot_d;
      addr_q  <= addr_d;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign rom_boot    = boot_q;
  assign rom_addr    = addr_q;
  assign instr       = instr_q.word;
  assign instr_pc    = instr_q.pc;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a cycle-level reference model and ROM.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        rom_boot;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        halted;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [15:0] rom [256];
  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Off-bus value stands in for the tri-stated bus so a stray sample is visible.
  assign rom_data = rom_boot ? rom[rom_addr] : 16'hDEAD;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rom_boot    (rom_boot),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halted      (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what should be visible after each edge.
  bit          m_run, m_fetch, m_valid, m_halt;
  logic [15:0] m_instr;
  logic [7:0]  m_ipc, m_pc;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_fetch = 0; m_valid = 0; m_halt = 0;
      m_instr = '0; m_ipc = '0; m_pc = '0;
    end
    chk("m_boot",   32'(rom_boot),    32'(m_fetch));
    chk("m_addr",   32'(rom_addr),    m_fetch ? 32'(m_pc) : 32'd0);
    chk("m_valid",  32'(instr_valid), 32'(m_valid));
    chk("m_halted", 32'(halted),      32'(m_halt));
    chk("m_instr",  32'(instr),       32'(m_instr));
    chk("m_ipc",    32'(instr_pc),    32'(m_ipc));
    if (rst_n) begin
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_fetch = 1;
        end
      end else if (jump_en) begin
        m_pc = {jump_addr[7:1], 1'b0};
        m_fetch = 1; m_valid = 0; m_halt = 0;
      end else if (m_fetch) begin
        if (HALT_EN && rom[m_pc] == 16'h0) begin
          m_halt = 1; m_fetch = 0;
        end else begin
          m_instr = rom[m_pc]; m_ipc = m_pc;
          m_pc = m_pc + 8'd2;
          m_valid = 1; m_fetch = 0;
        end
      end else if (m_valid && instr_ready) begin
        m_valid = 0; m_fetch = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hA000 | 16'(i);
    rom[8'h00] = 16'h2805;
    rom[8'h02] = 16'h2D12;
    rom[8'h04] = 16'h10FE;
    rom[8'h06] = 16'h4001;
    rom[8'h08] = 16'h0000;
    rom[8'hFE] = 16'hBEEF;

    rst_n = 0; start = 1; instr_ready = 1; jump_en = 0; jump_addr = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_boot",  32'(rom_boot),    32'd0);
    chk("rst_instr", 32'(instr),       32'd0);

    rst_n = 1;
    tick();
    chk("boot_first", 32'(rom_boot), 32'd1);
    chk("addr_first", 32'(rom_addr), 32'h00);
    tick();
    chk("instr0",  32'(instr),       32'h2805);
    chk("ipc0",    32'(instr_pc),    32'h00);
    chk("valid0",  32'(instr_valid), 32'd1);
    start = 0;
    tick();
    chk("gap_valid", 32'(instr_valid), 32'd0);
    chk("addr2",     32'(rom_addr),    32'h02);
    tick();
    chk("instr2", 32'(instr),    32'h2D12);
    chk("ipc2",   32'(instr_pc), 32'h02);

    instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_instr", 32'(instr),       32'h2D12);
      chk("bp_boot",  32'(rom_boot),    32'd0);
      chk("bp_valid", 32'(instr_valid), 32'd1);
    end
    instr_ready = 1;
    tick();
    chk("addr4", 32'(rom_addr), 32'h04);
    tick();
    chk("instr4", 32'(instr), 32'h10FE);
    tick();
    tick();
    chk("instr6", 32'(instr),    32'h4001);
    chk("ipc6",   32'(instr_pc), 32'h06);

    // Redirect while the current instruction is being accepted.
    jump_en = 1; jump_addr = 8'h13;
    tick();
    chk("jmp_valid_addr", 32'(rom_addr), 32'h12);
    // Redirect during FETCH: word at 0x12 is dropped.
    jump_addr = 8'h20;
    tick();
    chk("jmp_fetch_addr",  32'(rom_addr),    32'h20);
    chk("jmp_fetch_instr", 32'(instr),       32'h4001);
    chk("jmp_fetch_valid", 32'(instr_valid), 32'd0);
    jump_en = 0;
    tick();
    chk("jmp_ipc",   32'(instr_pc), 32'h20);
    chk("jmp_instr", 32'(instr),    32'hA020);

    jump_en = 1; jump_addr = 8'hFE;
    tick();
    jump_en = 0;
    chk("wrap_fetch", 32'(rom_addr), 32'hFE);
    tick();
    chk("wrap_instr", 32'(instr), 32'hBEEF);
    tick();
    chk("wrap_addr", 32'(rom_addr), 32'h00);
    chk("wrap_boot", 32'(rom_boot), 32'd1);
    tick();
    chk("wrap_ipc", 32'(instr_pc), 32'h00);

    // Asynchronous reset between edges while VALID.
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", 32'(instr),       32'd0);
    tick();
    rst_n = 1; start = 1;
    tick();
    chk("reboot_addr", 32'(rom_addr), 32'h00);
    start = 0;
    jump_en = 1; jump_addr = 8'h08;
    tick();
    jump_en = 0;
    chk("z_addr", 32'(rom_addr), 32'h08);
    tick();
`ifdef FETCH_HALT_EN
    chk("z_halted", 32'(halted),      32'd1);
    chk("z_valid",  32'(instr_valid), 32'd0);
    chk("z_boot",   32'(rom_boot),    32'd0);
    start = 1;
    tick();
    tick();
    chk("z_stay", 32'(halted), 32'd1);
    start = 0;
`else
    chk("z_halted", 32'(halted),      32'd0);
    chk("z_valid",  32'(instr_valid), 32'd1);
    chk("z_instr",  32'(instr),       32'h0000);
    chk("z_ipc",    32'(instr_pc),    32'h08);
`endif
    jump_en = 1; jump_addr = 8'h00;
    tick();
    jump_en = 0;
    chk("restart_halted", 32'(halted),   32'd0);
    chk("restart_addr",   32'(rom_addr), 32'h00);
    tick();
    chk("restart_instr", 32'(instr), 32'h2805);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
